// File: rtl/astropix_readout_pkg.sv
// Shared constants, state encoding and helpers for the AstroPix SPI readout framer.
package astropix_readout_pkg;

  localparam logic [7:0] IDLE_BYTE_K  = 8'hBC;
  localparam logic [7:0] IDLE_BYTE_FF = 8'hFF;

  localparam logic [2:0]  HDR_MARKER = 3'b001;
  localparam int unsigned LEN_W      = 5;

  localparam int unsigned LANES     = 7;
  localparam int unsigned LANE_BITS = LANES * 8;
  localparam int unsigned CNT_W     = 3;

  localparam int unsigned TAG_FIRST = 63;
  localparam int unsigned TAG_LAST  = 62;
  localparam int unsigned TAG_TRUNC = 61;
  localparam int unsigned TAG_CNT   = 56;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISCARD
  } state_t;

  function automatic logic is_idle_byte(input logic [7:0] b);
    return (b == IDLE_BYTE_K) || (b == IDLE_BYTE_FF);
  endfunction

  function automatic logic is_header(input logic [7:0] b);
    return b[7:5] == HDR_MARKER;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_hit_framer_if.sv
// Byte-in / FIFO-out signal bundle of the hit framer.
interface spi_hit_framer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [63:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;

  modport master (
    output byte_in, byte_valid, fifo_full,
    input  fifo_din, fifo_wr_en
  );

  modport slave (
    input  byte_in, byte_valid, fifo_full,
    output fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/framer_word_packer.sv
// 7-lane byte accumulator with tag assembly and registered FIFO word output.
module framer_word_packer
  import astropix_readout_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        start,
  input  logic        push,
  input  logic        flush,
  input  logic        wr,
  input  logic        last,
  input  logic        trunc,
  output logic        last_lane,
  output logic [63:0] fifo_din,
  output logic        fifo_wr_en
);

  logic [LANE_BITS-1:0] data_q;
  logic [LANE_BITS-1:0] data_word;
  logic [CNT_W-1:0]     idx_q;
  logic [CNT_W-1:0]     count;
  logic                 first_q;
  logic [63:0]          word;

  // The emitting byte is merged combinationally so a word leaves on the edge that accepts it.
  always_comb begin
    data_word = data_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (push && (idx_q == CNT_W'(i)))
        data_word[(LANES-1-i)*8 +: 8] = byte_in;
    end
    count = idx_q + CNT_W'(push);

    word             = '0;
    word[TAG_FIRST]  = first_q;
    word[TAG_LAST]   = last;
    word[TAG_TRUNC]  = trunc;
    word[TAG_CNT +: CNT_W] = count;
    word[LANE_BITS-1:0]    = data_word;
  end

  assign last_lane = (idx_q == CNT_W'(LANES-1));

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else if (start) begin
      data_q  <= {byte_in, {(LANE_BITS-8){1'b0}}};
      idx_q   <= CNT_W'(1);
      first_q <= 1'b1;
    end else if (flush) begin
      data_q  <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else if (push) begin
      data_q <= data_word;
      idx_q  <= idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
    end else begin
      fifo_wr_en <= wr;
      if (wr)
        fifo_din <= word;
    end
  end

endmodule

// File: rtl/spi_hit_framer.sv
// AstroPix hit-frame framer: idle stripping, header parsing, FIFO word tagging, counters.
// Optional frame timeout enabled by defining FRAMER_TIMEOUT_EN.
module spi_hit_framer
  import astropix_readout_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  spi_hit_framer_if.slave    bus,
  output logic [15:0]        frame_count,
  output logic [15:0]        drop_count,
  output logic [15:0]        sync_err_count
);

  state_t           state, state_next;
  logic [LEN_W-1:0] remaining, remaining_next;
  logic             start, push, flush, wr, last, trunc, last_lane;
  logic             inc_frame, inc_drop, inc_sync, timeout;
  logic             rem_one;

  assign rem_one = (remaining == LEN_W'(1));

`ifdef FRAMER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt;

  always_ff @(posedge clock) begin
    if (reset || (state == ST_IDLE) || bus.byte_valid)
      idle_cnt <= '0;
    else if (!timeout)
      idle_cnt <= idle_cnt + 16'd1;
  end

  assign timeout = (state != ST_IDLE) && !bus.byte_valid && (idle_cnt == TIMEOUT_LIM);
`else
  assign timeout = 1'b0;
  // Parameter kept so instantiations are identical across builds.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      remaining      <= '0;
      frame_count    <= '0;
      drop_count     <= '0;
      sync_err_count <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (inc_frame) frame_count    <= sat_inc(frame_count);
      if (inc_drop)  drop_count     <= sat_inc(drop_count);
      if (inc_sync)  sync_err_count <= sat_inc(sync_err_count);
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    start          = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;
    wr             = 1'b0;
    last           = 1'b0;
    trunc          = 1'b0;
    inc_frame      = 1'b0;
    inc_drop       = 1'b0;
    inc_sync       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.byte_valid && !is_idle_byte(bus.byte_in)) begin
          if (is_header(bus.byte_in) && (bus.byte_in[LEN_W-1:0] != '0)) begin
            start          = 1'b1;
            remaining_next = bus.byte_in[LEN_W-1:0];
            state_next     = ST_COLLECT;
          end else begin
            inc_sync = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (bus.byte_valid) begin
          push           = 1'b1;
          remaining_next = remaining - LEN_W'(1);
          if (rem_one) begin
            // A full FIFO on the closing word ends the frame immediately as a drop.
            flush      = 1'b1;
            last       = 1'b1;
            state_next = ST_IDLE;
            if (bus.fifo_full) begin
              inc_drop = 1'b1;
            end else begin
              wr        = 1'b1;
              inc_frame = 1'b1;
            end
          end else if (last_lane) begin
            flush = 1'b1;
            if (bus.fifo_full)
              state_next = ST_DISCARD;
            else
              wr = 1'b1;
          end
        end else if (timeout) begin
          flush      = 1'b1;
          last       = 1'b1;
          trunc      = 1'b1;
          wr         = !bus.fifo_full;
          inc_drop   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (bus.byte_valid) begin
          remaining_next = remaining - LEN_W'(1);
          if (rem_one) begin
            inc_drop   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (timeout) begin
          inc_drop   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  framer_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .byte_in    (bus.byte_in),
    .start      (start),
    .push       (push),
    .flush      (flush),
    .wr         (wr),
    .last       (last),
    .trunc      (trunc),
    .last_lane  (last_lane),
    .fifo_din   (bus.fifo_din),
    .fifo_wr_en (bus.fifo_wr_en)
  );

endmodule

// File: tb/tb_spi_hit_framer.sv
// Directed bench for spi_hit_framer; timeout expectations follow FRAMER_TIMEOUT_EN.
module tb_spi_hit_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] frame_count, drop_count, sync_err_count;

  spi_hit_framer_if bus ();

  spi_hit_framer #(.TIMEOUT_CYCLES(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .frame_count    (frame_count),
    .drop_count     (drop_count),
    .sync_err_count (sync_err_count)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [63:0] wq[$];
  int unsigned wc[$];
  always @(negedge clock) begin
    if (bus.fifo_wr_en === 1'b1) begin
      wq.push_back(bus.fifo_din);
      wc.push_back(cyc);
    end
  end

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned e_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic full = 1'b0);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bus.fifo_full  = full;
    @(posedge clock);
    #1;
    bus.byte_valid = 1'b0;
    bus.fifo_full  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.byte_in    = 8'h00;
    idle(2);
    reset = 1'b0;
    wq.delete();
    wc.delete();
  endtask

  task automatic check_word(input string tag, input int unsigned i, input logic [63:0] exp);
    if (wq.size() > i) check(tag, wq[i], exp);
    else check({tag, "_missing"}, 64'(wq.size()), 64'(i + 1));
  endtask

  initial begin
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.byte_in    = 8'h00;
    idle(3);
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("rst_din", bus.fifo_din, 64'd0);
    check("rst_frame", 64'(frame_count), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_sync", 64'(sync_err_count), 64'd0);
    reset = 1'b0;

    // idle filler is ignored
    for (int unsigned i = 0; i < 10; i++) begin
      put(8'hBC);
      put(8'hFF);
    end
    idle(3);
    check("idle_writes", 64'(wq.size()), 64'd0);
    check("idle_frame", 64'(frame_count), 64'd0);
    check("idle_sync", 64'(sync_err_count), 64'd0);
    check("idle_drop", 64'(drop_count), 64'd0);

    // single-word frame, latency check
    do_reset();
    put(8'h24); put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
    e_last = cyc;
    idle(3);
    check("f5_writes", 64'(wq.size()), 64'd1);
    check_word("f5_word", 0, 64'hC524A1A2A3A40000);
    if (wc.size() > 0) check("f5_latency", 64'(wc[0]), 64'(e_last));
    check("f5_frame", 64'(frame_count), 64'd1);

    // two-word frame, no bubble between words
    do_reset();
    put(8'h2A);
    for (int unsigned i = 1; i <= 10; i++) put(8'(i));
    idle(3);
    check("f11_writes", 64'(wq.size()), 64'd2);
    check_word("f11_word0", 0, 64'h872A010203040506);
    check_word("f11_word1", 1, 64'h440708090A000000);
    if (wc.size() > 1) check("f11_spacing", 64'(wc[1] - wc[0]), 64'd4);
    check("f11_frame", 64'(frame_count), 64'd1);

    // full FIFO on first emit discards the frame
    do_reset();
    put(8'h2A);
    for (int unsigned i = 1; i <= 10; i++) put(8'(i), i == 6);
    put(8'h24); put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
    idle(3);
    check("full_writes", 64'(wq.size()), 64'd1);
    check_word("full_next_word", 0, 64'hC524A1A2A3A40000);
    check("full_drop", 64'(drop_count), 64'd1);
    check("full_frame", 64'(frame_count), 64'd1);

    // stalled frame
    do_reset();
    put(8'h23); put(8'h11);
    e_last = cyc;
    idle(24);
`ifdef FRAMER_TIMEOUT_EN
    check("tmo_writes", 64'(wq.size()), 64'd1);
    check_word("tmo_word", 0, 64'hE223110000000000);
    if (wc.size() > 0) check("tmo_time", 64'(wc[0] - e_last), 64'd16);
    check("tmo_drop", 64'(drop_count), 64'd1);
`else
    check("tmo_writes", 64'(wq.size()), 64'd0);
    check("tmo_drop", 64'(drop_count), 64'd0);
`endif
    check("tmo_frame", 64'(frame_count), 64'd0);

    // sync errors: stray byte and zero-length header
    do_reset();
    put(8'h55);
    idle(2);
    check("sync_stray", 64'(sync_err_count), 64'd1);
    put(8'h20);
    idle(2);
    check("sync_n0", 64'(sync_err_count), 64'd2);

    // reset mid-frame
    do_reset();
    put(8'h2A); put(8'h01); put(8'h02);
    do_reset();
    idle(2);
    check("midrst_writes", 64'(wq.size()), 64'd0);
    check("midrst_frame", 64'(frame_count), 64'd0);
    check("midrst_drop", 64'(drop_count), 64'd0);
    check("midrst_sync", 64'(sync_err_count), 64'd0);
    put(8'h24); put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
    idle(3);
    check_word("midrst_next", 0, 64'hC524A1A2A3A40000);
    check("midrst_next_frame", 64'(frame_count), 64'd1);

    // back-to-back frames with no gap
    do_reset();
    put(8'h21); put(8'hB0); put(8'h21); put(8'hB1);
    idle(3);
    check("b2b_writes", 64'(wq.size()), 64'd2);
    check_word("b2b_word0", 0, 64'hC221B00000000000);
    check_word("b2b_word1", 1, 64'hC221B10000000000);
    check("b2b_frame", 64'(frame_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
